// File: rtl/ps2_key_event_queue_if.sv
// Key event queue bus: PS/2 byte input side, event consumer side and status.
// The slave modport is the queue itself; the master modport is whatever
// feeds it bytes and drains its events.
interface ps2_key_event_queue_if #(
  parameter int FIFO_DEPTH = 8
);

  logic [7:0]                         received_data;
  logic                               received_data_en;
  logic                               ev_valid;
  logic                               ev_ready;
  logic [7:0]                         ev_keycode;
  logic                               ev_release;
  logic                               ev_extended;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    ev_count;
  logic                               overflow;
  logic                               clear_overflow;
  logic                               any_key_held;

  modport master (
    output received_data,
    output received_data_en,
    output ev_ready,
    output clear_overflow,
    input  ev_valid,
    input  ev_keycode,
    input  ev_release,
    input  ev_extended,
    input  ev_count,
    input  overflow,
    input  any_key_held
  );

  modport slave (
    input  received_data,
    input  received_data_en,
    input  ev_ready,
    input  clear_overflow,
    output ev_valid,
    output ev_keycode,
    output ev_release,
    output ev_extended,
    output ev_count,
    output overflow,
    output any_key_held
  );

endinterface

// File: rtl/ps2_key_event_queue.sv
// PS/2 key event queue: parses the scancode byte stream (make, F0 break,
// E0 extended, E1 pause), translates scancodes to internal keycodes, keeps a
// held-key bitmap and queues press/release events in a first-word-fall-through
// FIFO drained by a valid/ready consumer.
module ps2_key_event_queue #(
  parameter int FIFO_DEPTH      = 8,
  parameter bit REPORT_RELEASE  = 1'b1,
  parameter bit SUPPRESS_REPEAT = 1'b1,
  parameter bit DROP_UNMAPPED   = 1'b1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  ps2_key_event_queue_if.slave   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Parser states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;

  // Scancode set 2 to internal keycode; 255 marks an unmapped code.
  function automatic logic [7:0] xlat(input logic [7:0] sc);
    logic [7:0] kc;
    case (sc)
      8'h45: kc = 8'd0;
      8'h16: kc = 8'd1;
      8'h1E: kc = 8'd2;
      8'h26: kc = 8'd3;
      8'h25: kc = 8'd4;
      8'h2E: kc = 8'd5;
      8'h36: kc = 8'd6;
      8'h3D: kc = 8'd7;
      8'h3E: kc = 8'd8;
      8'h46: kc = 8'd9;
      8'h1C: kc = 8'd10;
      8'h32: kc = 8'd11;
      8'h21: kc = 8'd12;
      8'h23: kc = 8'd13;
      8'h24: kc = 8'd14;
      8'h2B: kc = 8'd15;
      8'h34: kc = 8'd16;
      8'h33: kc = 8'd17;
      8'h43: kc = 8'd18;
      8'h3B: kc = 8'd19;
      8'h42: kc = 8'd20;
      8'h4B: kc = 8'd21;
      8'h3A: kc = 8'd22;
      8'h31: kc = 8'd23;
      8'h44: kc = 8'd24;
      8'h4D: kc = 8'd25;
      8'h15: kc = 8'd26;
      8'h2D: kc = 8'd27;
      8'h1B: kc = 8'd28;
      8'h2C: kc = 8'd29;
      8'h3C: kc = 8'd30;
      8'h2A: kc = 8'd31;
      8'h1D: kc = 8'd32;
      8'h22: kc = 8'd33;
      8'h35: kc = 8'd34;
      8'h1A: kc = 8'd35;
      8'h29: kc = 8'd36;
      8'h49: kc = 8'd38;
      8'h5A: kc = 8'd98;
      8'h72: kc = 8'd99;
      8'h75: kc = 8'd100;
      default: kc = 8'd255;
    endcase
    return kc;
  endfunction

  // Parser state
  logic [2:0]   state_r, state_next_s;
  logic [2:0]   skip_r, skip_next_s;
  logic         key_done_s;
  logic         key_break_s;
  logic         key_ext_s;

  // Event decision and held keys
  logic [7:0]   kc_s;
  logic         push_s;
  logic [9:0]   push_data_s;
  logic [127:0] held_r, held_next_s;
  logic         any_held_r;

  // FIFO
  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_inc_s;
  logic [CW-1:0] count_r, count_next_s;
  logic          pop_s, full_s, wr_en_s, drop_s;
  logic [9:0]    head_r, head_next_s;
  logic          valid_r;
  logic          overflow_r;

  // Byte-level parser: next state and completed-key strobe
  always_comb begin
    state_next_s = state_r;
    skip_next_s  = skip_r;
    key_done_s   = 1'b0;
    key_break_s  = 1'b0;
    key_ext_s    = 1'b0;
    if (bus.received_data_en) begin
      case (state_r)
        ST_IDLE: begin
          case (bus.received_data)
            8'hE0: state_next_s = ST_EXT;
            8'hF0: state_next_s = ST_BRK;
            8'hE1: begin
              state_next_s = ST_PAUSE;
              skip_next_s  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_next_s = ST_IDLE;
            default: key_done_s = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (bus.received_data == 8'hF0) begin
            state_next_s = ST_EXT_BRK;
          end else if (bus.received_data == 8'h12 || bus.received_data == 8'h59) begin
            // E0-prefixed fake shift sent around some extended keys
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_IDLE;
            key_done_s   = 1'b1;
            key_ext_s    = 1'b1;
          end
        end
        ST_BRK: begin
          state_next_s = ST_IDLE;
          key_done_s   = 1'b1;
          key_break_s  = 1'b1;
        end
        ST_EXT_BRK: begin
          state_next_s = ST_IDLE;
          key_done_s   = 1'b1;
          key_break_s  = 1'b1;
          key_ext_s    = 1'b1;
        end
        ST_PAUSE: begin
          // Pause sends a fixed 8-byte sequence with no break; swallow it whole
          if (skip_r == 3'd1) begin
            state_next_s = ST_IDLE;
          end else begin
            skip_next_s = skip_r - 3'd1;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Event filtering and held-bitmap update for a completed key
  always_comb begin
    kc_s         = xlat(bus.received_data);
    held_next_s  = held_r;
    push_s       = 1'b0;
    push_data_s  = {kc_s, key_break_s, key_ext_s};
    if (key_done_s) begin
      if (key_break_s) begin
        push_s = REPORT_RELEASE && !(DROP_UNMAPPED && kc_s == 8'd255);
        if (kc_s != 8'd255) begin
          held_next_s[kc_s[6:0]] = 1'b0;
        end else begin
          held_next_s = held_r;
        end
      end else begin
        push_s = !(SUPPRESS_REPEAT && kc_s != 8'd255 && held_r[kc_s[6:0]]) &&
                 !(DROP_UNMAPPED && kc_s == 8'd255);
        if (kc_s != 8'd255) begin
          held_next_s[kc_s[6:0]] = 1'b1;
        end else begin
          held_next_s = held_r;
        end
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO control: push/pop/drop decisions, next count and next head
  always_comb begin
    pop_s        = (count_r != '0) && bus.ev_ready;
    full_s       = (count_r == CW'(FIFO_DEPTH));
    wr_en_s      = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    rd_ptr_inc_s = rd_ptr_r + PW'(1);
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    head_next_s = head_r;
    if (pop_s) begin
      if (count_r == CW'(1)) begin
        // Last entry leaves; a simultaneous push becomes the new head
        if (wr_en_s) begin
          head_next_s = push_data_s;
        end else begin
          head_next_s = head_r;
        end
      end else begin
        head_next_s = mem_r[rd_ptr_inc_s];
      end
    end else begin
      if (count_r == '0 && wr_en_s) begin
        head_next_s = push_data_s;
      end else begin
        head_next_s = head_r;
      end
    end
  end

  // Parser and held-key registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      skip_r     <= 3'd0;
      held_r     <= '0;
      any_held_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      skip_r     <= skip_next_s;
      held_r     <= held_next_s;
      any_held_r <= |held_next_s;
    end
  end

  // FIFO storage
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // FIFO pointers, count, registered head and sticky overflow
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      head_r     <= 10'd0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      count_r <= count_next_s;
      head_r  <= head_next_s;
      valid_r <= (count_next_s != '0);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clear_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign bus.ev_valid     = valid_r;
  assign bus.ev_keycode   = head_r[9:2];
  assign bus.ev_release   = head_r[1];
  assign bus.ev_extended  = head_r[0];
  assign bus.ev_count     = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.any_key_held = any_held_r;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Bench for ps2_key_event_queue: directed byte sequences, a sequence-level
// reference model compared every cycle, plus literal checks on the event log.
module tb_ps2_key_event_queue;

  localparam int DEPTH = 8;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  ps2_key_event_queue_if #(.FIFO_DEPTH(DEPTH)) bus ();
  ps2_key_event_queue_if #(.FIFO_DEPTH(DEPTH)) bus2 ();

  ps2_key_event_queue #(
    .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1'b1), .SUPPRESS_REPEAT(1'b1), .DROP_UNMAPPED(1'b1)
  ) dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));

  ps2_key_event_queue #(
    .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1'b1), .SUPPRESS_REPEAT(1'b0), .DROP_UNMAPPED(1'b1)
  ) dut_rep (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus2));

  assign bus2.received_data    = bus.received_data;
  assign bus2.received_data_en = bus.received_data_en;
  assign bus2.ev_ready         = 1'b1;
  assign bus2.clear_overflow   = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_map [256];
  logic [7:0]  m_seq [$];
  logic [9:0]  m_q   [$];
  logic [9:0]  m_log [$];
  logic [255:0] m_held;
  logic        m_ov;
  logic [9:0]  m_last;
  logic        m_done, m_rel, m_ext, m_push, m_pop;
  logic [7:0]  m_b, m_kc;
  int          m_pre;

  logic [7:0] digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  initial begin
    for (int i = 0; i < 256; i++) m_map[i] = 8'd255;
    for (int i = 0; i < 10; i++) m_map[digit_codes[i]] = 8'(i);
    for (int i = 0; i < 26; i++) m_map[letter_codes[i]] = 8'(10 + i);
    m_map[8'h29] = 8'd36;
    m_map[8'h49] = 8'd38;
    m_map[8'h5A] = 8'd98;
    m_map[8'h72] = 8'd99;
    m_map[8'h75] = 8'd100;
  end

  // Model: collect each key sequence as a whole, then apply queue rules
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      m_seq.delete();
      m_q.delete();
      m_held = '0;
      m_ov   = 1'b0;
      m_last = 10'd0;
    end else begin
      m_done = 1'b0; m_rel = 1'b0; m_ext = 1'b0; m_push = 1'b0;
      m_b = bus.received_data;
      m_kc = m_map[m_b];
      if (bus.received_data_en) begin
        m_seq.push_back(m_b);
        if (m_seq[0] == 8'hE1) begin
          if (m_seq.size() == 8) m_seq.delete();
        end else if (m_seq.size() == 1) begin
          if (m_b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) m_seq.delete();
          else if (m_b != 8'hE0 && m_b != 8'hF0) m_done = 1'b1;
        end else if (m_seq[0] == 8'hE0 && m_seq.size() == 2) begin
          if (m_b == 8'h12 || m_b == 8'h59) m_seq.delete();
          else if (m_b != 8'hF0) begin m_done = 1'b1; m_ext = 1'b1; end
        end else begin
          m_done = 1'b1; m_rel = 1'b1; m_ext = (m_seq[0] == 8'hE0);
        end
        if (m_done) begin
          m_seq.delete();
          if (m_rel) begin
            m_push = (m_kc != 8'd255);
            if (m_kc != 8'd255) m_held[m_kc] = 1'b0;
          end else begin
            m_push = (m_kc != 8'd255) && !m_held[m_kc];
            if (m_kc != 8'd255) m_held[m_kc] = 1'b1;
          end
        end
      end
      m_pre = m_q.size();
      m_pop = (m_pre > 0) && bus.ev_ready;
      if (m_pop) begin
        m_last = m_q.pop_front();
        m_log.push_back(m_last);
      end
      if (m_push) begin
        if (m_pre == DEPTH && !m_pop) m_ov = 1'b1;
        else m_q.push_back({m_kc, m_rel, m_ext});
      end
      if (!(m_push && m_pre == DEPTH && !m_pop) && bus.clear_overflow) m_ov = 1'b0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge CLOCK_50) begin
    check("ev_count", 32'(bus.ev_count), 32'(m_q.size()));
    check("ev_valid", 32'(bus.ev_valid), 32'(m_q.size() != 0));
    check("overflow", 32'(bus.overflow), 32'(m_ov));
    check("any_key_held", 32'(bus.any_key_held), 32'(|m_held));
    check("head", 32'({bus.ev_keycode, bus.ev_release, bus.ev_extended}),
          32'((m_q.size() != 0) ? m_q[0] : m_last));
  end

  // Presses of keycode 10 seen from the repeat-passing instance
  int rep_press = 0;
  always @(negedge CLOCK_50) begin
    if (bus2.ev_valid && bus2.ev_keycode == 8'd10 && !bus2.ev_release) rep_press++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(negedge CLOCK_50);
    bus.received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check_reset_values();
    check("rst ev_valid", 32'(bus.ev_valid), 32'd0);
    check("rst ev_count", 32'(bus.ev_count), 32'd0);
    check("rst ev_keycode", 32'(bus.ev_keycode), 32'd0);
    check("rst ev_release", 32'(bus.ev_release), 32'd0);
    check("rst ev_extended", 32'(bus.ev_extended), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    check("rst any_key_held", 32'(bus.any_key_held), 32'd0);
  endtask

  int base, rbase;

  initial begin
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    bus.ev_ready         = 1'b1;
    bus.clear_overflow   = 1'b0;
    idle(3);
    check_reset_values();
    @(negedge CLOCK_50); #2 reset = 1'b0;

    // 1: make then break of A
    base = m_log.size();
    send(8'h1C);
    idle(1);
    check("t1 held after make", 32'(bus.any_key_held), 32'd1);
    send(8'hF0); send(8'h1C);
    idle(3);
    check("t1 log size", 32'(m_log.size() - base), 32'd2);
    check("t1 press", 32'(m_log[base]), 32'd40);
    check("t1 release", 32'(m_log[base+1]), 32'd42);
    check("t1 held after break", 32'(bus.any_key_held), 32'd0);

    // 2: extended make/break, fake shift
    base = m_log.size();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    idle(3);
    check("t2 log size", 32'(m_log.size() - base), 32'd2);
    check("t2 ext press", 32'(m_log[base]), 32'd401);
    check("t2 ext release", 32'(m_log[base+1]), 32'd403);

    // 3: typematic repeats
    base  = m_log.size();
    rbase = rep_press;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    idle(3);
    check("t3 log size", 32'(m_log.size() - base), 32'd2);
    check("t3 press", 32'(m_log[base]), 32'd40);
    check("t3 release", 32'(m_log[base+1]), 32'd42);
    check("t3 repeat presses", 32'(rep_press - rbase), 32'd3);

    // 4: fill, overflow, drain, clear, push+pop when full
    bus.ev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(digit_codes[i]);
    idle(1);
    check("t4 count full", 32'(bus.ev_count), 32'd8);
    check("t4 overflow", 32'(bus.overflow), 32'd1);
    check("t4 head key", 32'(bus.ev_keycode), 32'd1);
    base = m_log.size();
    bus.ev_ready = 1'b1;
    idle(10);
    bus.ev_ready = 1'b0;
    check("t4 drained", 32'(m_log.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) check("t4 drain order", 32'(m_log[base+i]), 32'((i + 1) * 4));
    check("t4 overflow sticky", 32'(bus.overflow), 32'd1);
    @(negedge CLOCK_50); bus.clear_overflow = 1'b1;
    @(negedge CLOCK_50); bus.clear_overflow = 1'b0;
    check("t4 overflow cleared", 32'(bus.overflow), 32'd0);
    for (int i = 1; i <= 8; i++) begin send(8'hF0); send(digit_codes[i]); end
    idle(1);
    check("t4 refill", 32'(bus.ev_count), 32'd8);
    send(8'hF0);
    @(negedge CLOCK_50);
    bus.received_data = digit_codes[9]; bus.received_data_en = 1'b1; bus.ev_ready = 1'b1;
    @(negedge CLOCK_50);
    bus.received_data_en = 1'b0; bus.ev_ready = 1'b0;
    check("t4 push+pop count", 32'(bus.ev_count), 32'd8);
    check("t4 push+pop no overflow", 32'(bus.overflow), 32'd0);
    check("t4 new head", 32'({bus.ev_keycode, bus.ev_release}), 32'(2 * 2 + 1));
    bus.ev_ready = 1'b1;
    idle(12);
    check("t4 last drained", 32'(m_log[m_log.size()-1]), 32'd38);

    // 5: pause sequence swallowed, then a real key; ack bytes ignored
    base = m_log.size();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h45);
    send(8'hFA); send(8'hAA);
    idle(3);
    check("t5 log size", 32'(m_log.size() - base), 32'd1);
    check("t5 key0 press", 32'(m_log[base]), 32'd0);
    check("t5 nothing queued", 32'(bus.ev_count), 32'd0);

    // 6: reset mid-sequence with events queued
    bus.ev_ready = 1'b0;
    send(8'h1C); send(8'h16); send(8'h1E);
    send(8'hE0); send(8'hF0);
    check("t6 queued", 32'(bus.ev_count), 32'd3);
    @(negedge CLOCK_50); #2 reset = 1'b1;
    @(negedge CLOCK_50);
    check_reset_values();
    #2 reset = 1'b0;
    bus.ev_ready = 1'b1;
    base = m_log.size();
    send(8'h16);
    idle(3);
    check("t6 log size", 32'(m_log.size() - base), 32'd1);
    check("t6 key1 press", 32'(m_log[base]), 32'd4);
    check("t6 head held", 32'({bus.ev_keycode, bus.ev_release, bus.ev_extended}), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
